// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer and program counter ahead of the memory block
// Optional FETCH_SKIP_IMM_EN: skip the immediate read when the opcode's IMM_FLAG_BIT is clear.
module fetch_unit #(
   parameter int                  PC_WIDTH     = 16,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                  IMM_FLAG_BIT = 7
) (
   input  logic                i_clk,
   input  logic                i_nrst,
   output logic [PC_WIDTH-1:0] o_address,
   output logic                o_addressEn,
   output logic                o_readDataSelect,
   output logic                o_immediateSelect,
   output logic                o_outEnable,
   input  logic [15:0]         i_readData,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [7:0]          o_opcode,
   output logic [7:0]          o_immediate,
   output logic [PC_WIDTH-1:0] o_pc,
   input  logic                i_jumpEn,
   input  logic [PC_WIDTH-1:0] i_jumpAddr,
   input  logic                i_busReq,
   output logic                o_busGrant,
   input  logic                i_halt
);

   typedef enum logic [2:0] {
      S_ADDR  = 3'd0,
      S_OP    = 3'd1,
      S_IMM   = 3'd2,
      S_ISSUE = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [7:0]          opcode_q, opcode_d;
   logic [7:0]          imm_q, imm_d;
   logic                addr_en, read_sel, imm_sel, out_en, valid;
   logic                unused_read_hi;

   assign unused_read_hi = ^i_readData[15:8];

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q  <= S_ADDR;
         pc_q     <= RESET_VECTOR;
         opcode_q <= 8'h00;
         imm_q    <= 8'h00;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         opcode_q <= opcode_d;
         imm_q    <= imm_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      opcode_d = opcode_q;
      imm_d    = imm_q;
      addr_en  = 1'b0;
      read_sel = 1'b0;
      imm_sel  = 1'b0;
      out_en   = 1'b0;
      valid    = 1'b0;
      case (state_q)
         S_ADDR: begin
            addr_en  = 1'b1;
            read_sel = 1'b1;
            state_d  = i_halt ? S_HALT : S_OP;
         end
         S_OP: begin
            out_en   = 1'b1;
            read_sel = 1'b1;
            opcode_d = i_readData[7:0];
            state_d  = S_IMM;
`ifdef FETCH_SKIP_IMM_EN
            if (!i_readData[IMM_FLAG_BIT]) begin
               imm_d   = 8'h00;
               state_d = S_ISSUE;
            end
`endif
         end
         S_IMM: begin
            out_en   = 1'b1;
            read_sel = 1'b1;
            imm_sel  = 1'b1;
            imm_d    = i_readData[7:0];
            state_d  = S_ISSUE;
         end
         S_ISSUE: begin
            valid = 1'b1;
            // jump target is only honoured on the accepting cycle
            if (i_ready) begin
               pc_d    = i_jumpEn ? i_jumpAddr : pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
               state_d = S_ADDR;
            end
         end
         S_HALT: begin
            if (!i_halt) state_d = S_ADDR;
         end
         default: state_d = S_ADDR;
      endcase
   end

   // ADDR is the reset state, so its strobes are masked while reset is held
   assign o_addressEn       = addr_en & i_nrst;
   assign o_readDataSelect  = read_sel & i_nrst;
   assign o_immediateSelect = imm_sel;
   assign o_outEnable       = out_en;
   assign o_valid           = valid;
   assign o_address         = pc_q;
   assign o_pc              = pc_q;
   assign o_opcode          = opcode_q;
   assign o_immediate       = imm_q;
   assign o_busGrant        = i_busReq & ((state_q == S_ISSUE) || (state_q == S_HALT));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit with a cycle-timeline reference model
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        nrst;
   logic [15:0] o_address;
   logic        o_addressEn, o_readDataSelect, o_immediateSelect, o_outEnable;
   logic [15:0] rd_data;
   logic        o_valid;
   logic        ready;
   logic [7:0]  o_opcode, o_immediate;
   logic [15:0] o_pc;
   logic        jump_en;
   logic [15:0] jump_addr;
   logic        bus_req;
   logic        o_busGrant;
   logic        halt;

   int errors = 0;
   int checks = 0;

   fetch_unit dut (
      .i_clk(clk), .i_nrst(nrst),
      .o_address(o_address), .o_addressEn(o_addressEn),
      .o_readDataSelect(o_readDataSelect), .o_immediateSelect(o_immediateSelect),
      .o_outEnable(o_outEnable), .i_readData(rd_data),
      .o_valid(o_valid), .i_ready(ready),
      .o_opcode(o_opcode), .o_immediate(o_immediate), .o_pc(o_pc),
      .i_jumpEn(jump_en), .i_jumpAddr(jump_addr),
      .i_busReq(bus_req), .o_busGrant(o_busGrant), .i_halt(halt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] op_of(input logic [15:0] a);
      logic [15:0] t;
      t = a * 16'd37 + 16'd11;
      if (a == 16'h0000) return 8'h10;
      if (a == 16'h0001) return 8'h20;
      return t[7:0];
   endfunction

   function automatic logic [7:0] imm_of(input logic [15:0] a);
      logic [15:0] t;
      t = (a * 16'd13) ^ 16'h0096;
      if (a == 16'h0000) return 8'hA5;
      if (a == 16'h0001) return 8'h5A;
      return t[7:0];
   endfunction

   function automatic bit has_imm(input logic [15:0] a);
      logic [7:0] op;
      op = op_of(a);
`ifdef FETCH_SKIP_IMM_EN
      return op[7];
`else
      return (op == op) ? 1'b1 : 1'b0;
`endif
   endfunction

   // memory block: address latched on the strobe, bank chosen by the select line
   logic [15:0] mem_addr = 16'h0000;
   always @(posedge clk) if (o_addressEn) mem_addr <= o_address;
   always_comb begin
      rd_data = 16'hDEAD;
      if (o_outEnable)
         rd_data = {mem_addr[7:0] ^ 8'hC3, o_immediateSelect ? imm_of(mem_addr) : op_of(mem_addr)};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: cycles elapsed since the address phase of the current fetch
   logic [15:0] mpc = 16'h0000;
   int          since = 0;
   bit          halted = 0;

   always @(negedge clk) begin
      int     issue_at;
      bit     imm_present;
      if (!nrst) begin
         chk("rst_valid", o_valid, 0);
         chk("rst_aen", o_addressEn, 0);
         chk("rst_oe", o_outEnable, 0);
         chk("rst_rds", o_readDataSelect, 0);
         chk("rst_address", o_address, 16'h0000);
         chk("rst_pc", o_pc, 16'h0000);
         chk("rst_grant", o_busGrant, 0);
         mpc = 16'h0000; since = 0; halted = 0;
      end else if (halted) begin
         chk("halt_memctl", {o_addressEn, o_outEnable, o_readDataSelect, o_immediateSelect}, 0);
         chk("halt_valid", o_valid, 0);
         chk("halt_grant", o_busGrant, bus_req);
         if (!halt) begin halted = 0; since = 0; end
      end else begin
         imm_present = has_imm(mpc);
         issue_at = imm_present ? 3 : 2;
         chk("m_aen", o_addressEn, since == 0);
         if (since == 0) chk("m_address", o_address, mpc);
         chk("m_oe", o_outEnable, (since == 1) || (imm_present && since == 2));
         chk("m_rds", o_readDataSelect, since < issue_at);
         chk("m_immsel", o_immediateSelect, imm_present && since == 2);
         chk("m_valid", o_valid, since >= issue_at);
         chk("m_grant", o_busGrant, (since >= issue_at) && bus_req);
         if (since >= issue_at) begin
            chk("m_pc", o_pc, mpc);
            chk("m_opcode", o_opcode, op_of(mpc));
            chk("m_imm", o_immediate, imm_present ? imm_of(mpc) : 8'h00);
         end
         if (since == 0 && halt) halted = 1;
         else if (since >= issue_at) begin
            if (ready) begin
               mpc = jump_en ? jump_addr : mpc + 16'd1;
               since = 0;
            end
         end else since++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk); #1;
      while (!o_valid && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      chk("wait_valid", o_valid, 1);
   endtask

   initial begin
      logic [7:0] lit_imm0, lit_imm1;
      int n;
`ifdef FETCH_SKIP_IMM_EN
      lit_imm0 = 8'h00; lit_imm1 = 8'h00;
`else
      lit_imm0 = 8'hA5; lit_imm1 = 8'h5A;
`endif
      nrst = 1'b1; ready = 1'b1; jump_en = 1'b0; jump_addr = 16'h0000;
      bus_req = 1'b0; halt = 1'b0;
      #2 nrst = 1'b0;
      repeat (3) @(negedge clk);
      tick();
      nrst = 1'b1;
      #1;
      chk("rel_aen", o_addressEn, 1);
      chk("rel_address", o_address, 16'h0000);

      // sequential fetch
      wait_valid();
      chk("seq0_pc", o_pc, 16'h0000);
      chk("seq0_op", o_opcode, 8'h10);
      chk("seq0_imm", o_immediate, lit_imm0);
      wait_valid();
      chk("seq1_pc", o_pc, 16'h0001);
      chk("seq1_op", o_opcode, 8'h20);
      chk("seq1_imm", o_immediate, lit_imm1);

      // backpressure with an ignored jump, then a taken jump
      tick();
      ready = 1'b0;
      wait_valid();
      tick();
      jump_en = 1'b1; jump_addr = 16'h0777;
      repeat (4) tick();
      chk("bp_valid", o_valid, 1);
      chk("bp_pc", o_pc, 16'h0002);
      jump_addr = 16'h0123; ready = 1'b1;
      tick();
      chk("jump_aen", o_addressEn, 1);
      chk("jump_address", o_address, 16'h0123);
      jump_en = 1'b0; ready = 1'b0; bus_req = 1'b1;
      #1 chk("bus_early", o_busGrant, 0);

      // bus grant only once the instruction is on offer
      wait_valid();
      chk("bus_grant", o_busGrant, 1);
      chk("bus_quiet", {o_addressEn, o_outEnable, o_readDataSelect, o_immediateSelect}, 0);
      tick();
      ready = 1'b1;
      tick();
      chk("bus_drop", o_busGrant, 0);
      bus_req = 1'b0; halt = 1'b1;

      // halt from ADDR, resume at same PC
      repeat (6) begin
         tick();
         bus_req = 1'($urandom_range(0, 1));
      end
      chk("halt_valid_d", o_valid, 0);
      halt = 1'b0; bus_req = 1'b0;
      wait_valid();
      chk("resume_pc", o_pc, 16'h0124);

      // wrap at the top of the address space
      tick();
      jump_en = 1'b1; jump_addr = 16'hFFFF;
      wait_valid();
      tick();
      jump_en = 1'b0;
      wait_valid();
      chk("wrap_pc", o_pc, 16'hFFFF);
      tick();
      chk("wrap_aen", o_addressEn, 1);
      chk("wrap_address", o_address, 16'h0000);

      // randomized traffic
      repeat (600) begin
         tick();
         ready     = 1'($urandom_range(0, 1));
         jump_en   = ($urandom_range(0, 7) == 0);
         jump_addr = 16'($urandom);
         bus_req   = 1'($urandom_range(0, 1));
         halt      = ($urandom_range(0, 15) == 0) || (halt && 1'($urandom_range(0, 1)));
      end
      tick();
      ready = 1'b1; jump_en = 1'b0; bus_req = 1'b0; halt = 1'b0;

      // reset pulse in the immediate phase
      n = 0;
      @(negedge clk); #1;
      while (!o_immediateSelect && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      chk("find_imm", o_immediateSelect, 1);
      nrst = 1'b0;
      #1;
      chk("mid_valid", o_valid, 0);
      chk("mid_aen", o_addressEn, 0);
      chk("mid_address", o_address, 16'h0000);
      chk("mid_pc", o_pc, 16'h0000);
      tick();
      tick();
      nrst = 1'b1;
      wait_valid();
      chk("after_pc", o_pc, 16'h0000);
      chk("after_op", o_opcode, 8'h10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch sequencer and program counter; sits directly upstream of the memory block.
- Drives the memory block's latched address, program/data select, immediate-bank select and output enable.
- Captures the 8-bit opcode and the 8-bit immediate stored at the same address in the immediate ROM bank.
- Presents each instruction to the decoder over a valid/ready handshake. Yields the memory bus to the execute stage on request.

Parameters:
- PC_WIDTH, 16, program counter and address bus width.
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- IMM_FLAG_BIT, 7, opcode bit marking "immediate present"; used only with FETCH_SKIP_IMM_EN.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_nrst  in  1  asynchronous active-low reset.
- o_address  out  PC_WIDTH  address to memory block, valid while o_addressEn=1.
- o_addressEn  out  1  memory address register load strobe.
- o_readDataSelect  out  1  1 = program ROM path, 0 = data RAM.
- o_immediateSelect  out  1  1 = immediate ROM bank, 0 = opcode bank.
- o_outEnable  out  1  memory read output enable.
- i_readData  in  16  memory read bus; bits [7:0] used.
- o_valid  out  1  instruction available to decoder.
- i_ready  in  1  decoder accepts instruction.
- o_opcode  out  8  fetched opcode.
- o_immediate  out  8  fetched immediate.
- o_pc  out  PC_WIDTH  address of the presented instruction.
- i_jumpEn  in  1  redirect PC; sampled only on handshake.
- i_jumpAddr  in  PC_WIDTH  jump target.
- i_busReq  in  1  execute stage requests the memory bus.
- o_busGrant  out  1  fetch has released the memory bus.
- i_halt  in  1  stop fetching after the current issue.

Behaviour:
- Reset: asynchronous, active-low. Affects every register, including a reset asserted mid-operation.
  - PC=RESET_VECTOR, state=ADDR.
  - All outputs 0, except o_address=RESET_VECTOR and o_pc=RESET_VECTOR.
- The FSM is registered. All memory-control outputs decode from the current state (Moore).
- ADDR:
  - o_addressEn=1, o_address=PC, o_readDataSelect=1.
  - Next state OP, unless i_halt=1, which goes to HALT.
- OP:
  - o_outEnable=1, o_readDataSelect=1, o_immediateSelect=0.
  - Opcode register captures i_readData[7:0] at the clock edge. Next state IMM.
- IMM:
  - o_outEnable=1, o_readDataSelect=1, o_immediateSelect=1.
  - Immediate register captures i_readData[7:0]. Next state ISSUE.
- ISSUE:
  - o_valid=1; o_opcode, o_immediate and o_pc held stable until the handshake.
  - Handshake is o_valid & i_ready.
  - On handshake: PC <= i_jumpEn ? i_jumpAddr : PC+1, then next state ADDR.
  - The increment wraps modulo 2^PC_WIDTH (16'hFFFF -> 16'h0000).
  - i_jumpEn without the handshake is ignored.
- Bus grant:
  - o_busGrant=1 only in ISSUE or HALT, and only while i_busReq=1. It is combinational from state & i_busReq.
  - Memory-control outputs are already 0 in those states, so the execute stage owns the bus without contention.
  - Bus requests in ADDR/OP/IMM are not granted until ISSUE is reached. Latency from ADDR to grant is 3 cycles.
- Handshake and bus grant may coincide. The handshake still completes and the FSM moves to ADDR, so o_busGrant drops the next cycle. The execute stage must re-request.
- HALT:
  - All memory-control outputs 0, o_valid=0.
  - Leaves to ADDR when i_halt=0. PC is unchanged.
- Latency: opcode presented 3 cycles after entering ADDR. Minimum 4 cycles per instruction with i_ready held high.
- Outputs never change during ISSUE while o_valid=1 and i_ready=0.

Optional Feature:
- Macro: FETCH_SKIP_IMM_EN.
- Defined:
  - In OP, if i_readData[IMM_FLAG_BIT]=0, next state is ISSUE, skipping IMM; o_immediate=8'h00.
  - 3 cycles per instruction without an immediate.
- Undefined: IMM is always visited and IMM_FLAG_BIT is ignored.

Test Plan:
- Reset: hold i_nrst=0, then release.
  - During reset: o_valid=0, o_address=16'h0000, o_addressEn=0.
  - First cycle after release: o_addressEn=1, o_address=16'h0000.
- Sequential fetch with i_ready=1. ROM opcode bank has 0x10,0x20 at addresses 0,1; immediate bank has 0xA5,0x5A.
  - Issues (pc0,0x10,0xA5) then (pc1,0x20,0x5A).
  - o_valid rises every 4th cycle.
- Backpressure: i_ready=0 for 5 cycles in ISSUE.
  - o_valid remains 1; opcode, immediate and pc are stable.
  - No o_addressEn pulse; PC advances only after i_ready=1.
- Jump: i_jumpEn=1, i_jumpAddr=16'h0123 with the handshake → next o_address=16'h0123.
  - Jump asserted with i_ready=0 → no effect.
- Bus grant:
  - i_busReq=1 during OP → o_busGrant=0 until ISSUE, then 1; all memory-control outputs are 0 while granted.
  - i_halt=1 → HALT entered from ADDR; o_busGrant follows i_busReq; resume on i_halt=0 at the same PC.
- Wrap and reset mid-fetch:
  - PC=16'hFFFF, handshake without jump → next o_address=16'h0000.
  - i_nrst pulsed low during IMM → immediately state=ADDR, PC=RESET_VECTOR, o_valid=0.
